// File: rtl/branch_target_buffer_dp.sv
// Direct-mapped branch target buffer with per-entry 2-bit saturating direction counters.
// Lookup is combinational from the fetch PC; training comes from the resolved-branch port.
module branch_target_buffer_dp #(
  parameter int ENTRIES  = 16,
  parameter int IDX_BITS = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        clear,
  input  logic [31:0] pc,
  input  logic        update_en,
  input  logic        update_outcome,
  input  logic [31:0] update_pc,
  input  logic [31:0] update_target,
  output logic [31:0] target,
  output logic        pred
);

  localparam int TAG_BITS = 30 - IDX_BITS;

  logic                valid_r [ENTRIES];
  logic [TAG_BITS-1:0] tag_r   [ENTRIES];
  logic [31:0]         tgt_r   [ENTRIES];
  logic [1:0]          ctr_r   [ENTRIES];

  logic [IDX_BITS-1:0] lk_idx_s;
  logic [TAG_BITS-1:0] lk_tag_s;
  logic                lk_hit_s;
  logic [IDX_BITS-1:0] up_idx_s;
  logic [TAG_BITS-1:0] up_tag_s;
  logic                up_match_s;
  logic                unused_s;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    if (c == 2'b11) return 2'b11;
    else return c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    if (c == 2'b00) return 2'b00;
    else return c - 2'b01;
  endfunction

  // Byte offset bits never participate in index or tag.
  assign unused_s = ^{pc[1:0], update_pc[1:0]};

  // Fetch-side lookup: pre-update state is visible in the same cycle.
  always_comb begin
    lk_idx_s = pc[IDX_BITS+1:2];
    lk_tag_s = pc[31:IDX_BITS+2];
    lk_hit_s = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
    if (lk_hit_s) begin
      target = tgt_r[lk_idx_s];
      pred   = ctr_r[lk_idx_s][1];
    end else begin
      target = 32'h0000_0000;
      pred   = 1'b0;
    end
  end

  // Decode of the entry addressed by the resolved branch.
  always_comb begin
    up_idx_s   = update_pc[IDX_BITS+1:2];
    up_tag_s   = update_pc[31:IDX_BITS+2];
    up_match_s = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);
  end

  // Entry storage: clear wins over training; a taken miss allocates over any alias.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i] <= 1'b0;
        ctr_r[i]   <= 2'b00;
      end
    end else if (update_en) begin
      if (up_match_s) begin
        if (update_outcome) begin
          ctr_r[up_idx_s] <= ctr_inc(ctr_r[up_idx_s]);
          tgt_r[up_idx_s] <= update_target;
        end else begin
          ctr_r[up_idx_s] <= ctr_dec(ctr_r[up_idx_s]);
        end
      end else if (update_outcome) begin
        valid_r[up_idx_s] <= 1'b1;
        tag_r[up_idx_s]   <= up_tag_s;
        tgt_r[up_idx_s]   <= update_target;
        ctr_r[up_idx_s]   <= 2'b10;
      end else begin
        valid_r[up_idx_s] <= valid_r[up_idx_s];
      end
    end else begin
      valid_r[0] <= valid_r[0];
    end
  end

endmodule

// File: tb/tb_branch_target_buffer_dp.sv
// Directed plus randomized bench for branch_target_buffer_dp against an array-based model.
module tb_branch_target_buffer_dp;

  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        update_en = 1'b0;
  logic        update_outcome = 1'b0;
  logic [31:0] update_pc = 32'h0;
  logic [31:0] update_target = 32'h0;
  logic [31:0] target;
  logic        pred;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: 16 entries, counter kept as a plain integer 0..3.
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];

  branch_target_buffer_dp dut (
    .clk(clk), .clear(clear), .pc(pc), .update_en(update_en),
    .update_outcome(update_outcome), .update_pc(update_pc),
    .update_target(update_target), .target(target), .pred(pred)
  );

  always #5 clk = ~clk;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % 32'd16);
  endfunction

  task automatic model_apply(input bit clr, input bit en, input bit outc,
                             input logic [31:0] upc, input logic [31:0] utgt);
    int i;
    bit hit;
    if (clr) begin
      for (int k = 0; k < 16; k++) begin
        m_valid[k] = 1'b0;
        m_ctr[k]   = 0;
      end
    end else if (en) begin
      i   = idx_of(upc);
      hit = m_valid[i] && (m_tag[i] == (upc >> 6));
      if (hit && outc) begin
        m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = utgt;
      end else if (hit) begin
        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
      end else if (outc) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = upc >> 6;
        m_tgt[i]   = utgt;
        m_ctr[i]   = 2;
      end
    end
  endtask

  task automatic compare(input string tag, input logic [31:0] et, input logic ep);
    vectors++;
    assert (target === et) else begin
      miscompares++;
      $error("FAIL %s target got %h expected %h", tag, target, et);
    end
    vectors++;
    assert (pred === ep) else begin
      miscompares++;
      $error("FAIL %s pred got %b expected %b", tag, pred, ep);
    end
  endtask

  // One cycle: drive at negedge, check just after, model commits at the posedge.
  task automatic step(input logic [31:0] lpc, input bit clr, input bit en, input bit outc,
                      input logic [31:0] upc, input logic [31:0] utgt,
                      input bit chk, input bit cc, input logic [31:0] et, input bit ep,
                      input string tag);
    int i;
    bit hit;
    @(negedge clk);
    pc = lpc; clear = clr; update_en = en; update_outcome = outc;
    update_pc = upc; update_target = utgt;
    #1;
    if (chk) begin
      i   = idx_of(lpc);
      hit = m_valid[i] && (m_tag[i] == (lpc >> 6));
      compare({tag, "_model"}, hit ? m_tgt[i] : 32'h0, hit && (m_ctr[i] >= 2));
    end
    if (cc) compare(tag, et, ep);
    @(posedge clk);
    model_apply(clr, en, outc, upc, utgt);
  endtask

  task automatic upd(input logic [31:0] upc, input bit outc, input logic [31:0] utgt);
    step(32'h0, 1'b0, 1'b1, outc, upc, utgt, 1'b1, 1'b0, 32'h0, 1'b0, "upd");
  endtask

  task automatic look(input logic [31:0] lpc, input logic [31:0] et, input bit ep, input string tag);
    step(lpc, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, et, ep, tag);
  endtask

  initial begin
    logic [31:0] rpc, rupc, rtgt;
    bit ren, rout, rclr;

    // 1: clear then miss
    step(32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, "clr");
    look(32'h0040_0010, 32'h0, 1'b0, "after_clear");
    // 2: allocate weakly taken
    upd(32'h0040_0010, 1'b1, 32'h0040_0100);
    look(32'h0040_0010, 32'h0040_0100, 1'b1, "alloc");
    look(32'h0040_0013, 32'h0040_0100, 1'b1, "low_bits_ignored");
    // 3: decrement to zero and saturate
    upd(32'h0040_0010, 1'b0, 32'hDEAD_0000);
    look(32'h0040_0010, 32'h0040_0100, 1'b0, "nt1");
    upd(32'h0040_0010, 1'b0, 32'h0);
    look(32'h0040_0010, 32'h0040_0100, 1'b0, "nt2");
    upd(32'h0040_0010, 1'b0, 32'h0);
    look(32'h0040_0010, 32'h0040_0100, 1'b0, "nt3_sat");
    // 4: climb and saturate high
    upd(32'h0040_0010, 1'b1, 32'h0040_0100);
    look(32'h0040_0010, 32'h0040_0100, 1'b0, "t1_ctr01");
    upd(32'h0040_0010, 1'b1, 32'h0040_0100);
    look(32'h0040_0010, 32'h0040_0100, 1'b1, "t2_ctr10");
    upd(32'h0040_0010, 1'b1, 32'h0040_0100);
    upd(32'h0040_0010, 1'b1, 32'h0040_0100);
    upd(32'h0040_0010, 1'b0, 32'h0);
    look(32'h0040_0010, 32'h0040_0100, 1'b1, "sat_then_nt");
    upd(32'h0040_0010, 1'b0, 32'h0);
    look(32'h0040_0010, 32'h0040_0100, 1'b0, "sat_nt_nt");
    // 5: aliasing and no-op not-taken miss
    upd(32'h0040_0050, 1'b1, 32'h0040_1000);
    look(32'h0040_0050, 32'h0040_1000, 1'b1, "alias_hit");
    look(32'h0040_0010, 32'h0, 1'b0, "alias_evicted");
    upd(32'h0040_0010, 1'b0, 32'h1234_5678);
    upd(32'h0040_0090, 1'b0, 32'h1234_5678);
    look(32'h0040_0050, 32'h0040_1000, 1'b1, "nt_miss_noop");
    // same-cycle lookup shows pre-update state
    step(32'h0040_0010, 1'b0, 1'b1, 1'b1, 32'h0040_0010, 32'h0040_0200,
         1'b1, 1'b1, 32'h0, 1'b0, "same_cycle_pre");
    look(32'h0040_0010, 32'h0040_0200, 1'b1, "same_cycle_post");
    // 6: clear beats update; then target overwrite on a match
    step(32'h0, 1'b1, 1'b1, 1'b1, 32'h0040_0020, 32'h0040_0800,
         1'b1, 1'b0, 32'h0, 1'b0, "clr_upd");
    look(32'h0040_0020, 32'h0, 1'b0, "clr_prio");
    look(32'h0040_0010, 32'h0, 1'b0, "clr_all");
    upd(32'h0040_0010, 1'b1, 32'h0040_0300);
    upd(32'h0040_0010, 1'b1, 32'h0040_0400);
    look(32'h0040_0010, 32'h0040_0400, 1'b1, "tgt_overwrite");

    // Randomized traffic over a small PC pool so hits and aliases are frequent.
    for (int n = 0; n < 600; n++) begin
      rpc  = 32'h0040_0000 | ($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      rupc = 32'h0040_0000 | ($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) rpc = $urandom;
      rtgt = $urandom;
      ren  = ($urandom_range(0, 3) != 0);
      rout = $urandom_range(0, 1);
      rclr = ($urandom_range(0, 79) == 0);
      step(rpc, rclr, ren, rout, rupc, rtgt, 1'b1, 1'b0, 32'h0, 1'b0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
